// File: rtl/uc_lectura.sv
// Read-side drain of the dual-clock FIFO: pops every word, re-checks odd parity,
// presents accepted words over valid/ready and keeps word / parity-error counters.
module uc_lectura #(
  parameter int DW       = 16,
  parameter int CW       = 16,
  parameter bit DROP_ERR = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rempty,
  input  logic [DW-1:0] rdata,
  output logic          rinc,
  input  logic          clr,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_err,
  output logic          par_err,
  output logic [CW-1:0] rd_count,
  output logic [CW-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_err_q, out_err_d;
  logic          par_err_q, par_err_d;
  logic [CW-1:0] rd_count_q, rd_count_d;
  logic [CW-1:0] err_count_q, err_count_d;
  logic          word_odd;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    par_err_d   = par_err_q;
    rd_count_d  = rd_count_q;
    err_count_d = err_count_q;
    word_odd    = ^rdata;

    unique case (state_q)
      IDLE: begin
        if (!rempty) state_d = LOAD;
      end
      LOAD: begin
        out_data_d = rdata;
        out_err_d  = ~word_odd;
        rd_count_d = rd_count_q + CW'(1);
        if (!word_odd) begin
          err_count_d = sat_inc(err_count_q);
          par_err_d   = 1'b1;
        end
        // A dropped word skips SEND, so back-to-back drops pop on consecutive cycles.
        if (word_odd || !DROP_ERR) state_d = SEND;
        else if (!rempty)          state_d = LOAD;
        else                       state_d = IDLE;
      end
      SEND: begin
        if (out_ready) state_d = rempty ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over any increment in the same cycle; it leaves the datapath alone.
    if (clr) begin
      rd_count_d  = '0;
      err_count_d = '0;
      par_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      par_err_q   <= 1'b0;
      rd_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      par_err_q   <= par_err_d;
      rd_count_q  <= rd_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign rinc      = (state_q == LOAD);
  assign out_valid = (state_q == SEND);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign par_err   = par_err_q;
  assign rd_count  = rd_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_uc_lectura.sv
// Bench for uc_lectura: two instances (drop mode with 4-bit counters, flag mode with
// 16-bit counters), each fed by a queue-modelled FIFO and compared to a stream model.
module tb_uc_lectura;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rempty_a, rempty_b;
  logic [15:0] rdata_a, rdata_b;
  logic        rinc_a, rinc_b;
  logic        clr_a, clr_b;
  logic [15:0] out_data_a, out_data_b;
  logic        out_valid_a, out_valid_b;
  logic        out_ready_a, out_ready_b;
  logic        out_err_a, out_err_b;
  logic        par_err_a, par_err_b;
  logic [3:0]  rd_count_a, err_count_a;
  logic [15:0] rd_count_b, err_count_b;

  uc_lectura #(.DW(16), .CW(4), .DROP_ERR(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rempty(rempty_a), .rdata(rdata_a), .rinc(rinc_a),
    .clr(clr_a), .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_err(out_err_a), .par_err(par_err_a), .rd_count(rd_count_a), .err_count(err_count_a)
  );

  uc_lectura #(.DW(16), .CW(16), .DROP_ERR(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rempty(rempty_b), .rdata(rdata_b), .rinc(rinc_b),
    .clr(clr_b), .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_err(out_err_b), .par_err(par_err_b), .rd_count(rd_count_b), .err_count(err_count_b)
  );

  // FIFO contents, reference streams ({err, data}) and observed handshakes
  logic [15:0] fq_a[$], fq_b[$];
  logic [16:0] exp_a[$], exp_b[$];
  logic [16:0] got_a[$], got_b[$];
  int          hs_a[$];
  int          n_a, e_a, n_b, e_b;
  int          pops_a, pops_b, viol_a, viol_b;
  int          cyc;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void refresh();
    rempty_a = (fq_a.size() == 0);
    rdata_a  = rempty_a ? 16'h0 : fq_a[0];
    rempty_b = (fq_b.size() == 0);
    rdata_b  = rempty_b ? 16'h0 : fq_b[0];
  endfunction

  // FIFO read side: a pop strobe seen at an edge removes the head just after it
  always @(posedge clk) begin
    logic pa, pb;
    pa = rinc_a && rst_n;
    pb = rinc_b && rst_n;
    cyc++;
    #1;
    if (pa) begin
      pops_a++;
      if (fq_a.size() == 0) viol_a++; else void'(fq_a.pop_front());
    end
    if (pb) begin
      pops_b++;
      if (fq_b.size() == 0) viol_b++; else void'(fq_b.pop_front());
    end
    refresh();
  end

  // Handshake capture plus hold-stable checking on the falling edge
  logic        pv_a, pv_b;
  logic [16:0] pw_a, pw_b;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv_a = 1'b0;
      pv_b = 1'b0;
    end else begin
      if (pv_a) check("hold_a", 32'({out_valid_a, out_err_a, out_data_a}), 32'({1'b1, pw_a}));
      if (pv_b) check("hold_b", 32'({out_valid_b, out_err_b, out_data_b}), 32'({1'b1, pw_b}));
      if (out_valid_a && out_ready_a) begin
        got_a.push_back({out_err_a, out_data_a});
        hs_a.push_back(cyc);
      end
      if (out_valid_b && out_ready_b) got_b.push_back({out_err_b, out_data_b});
      pv_a = out_valid_a && !out_ready_a;
      pw_a = {out_err_a, out_data_a};
      pv_b = out_valid_b && !out_ready_b;
      pw_b = {out_err_b, out_data_b};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: drop mode forwards only odd words; flag mode forwards all with err = even
  task automatic push_a(input logic [15:0] w);
    fq_a.push_back(w);
    n_a++;
    if (^w) exp_a.push_back({1'b0, w}); else e_a++;
    refresh();
  endtask

  task automatic push_b(input logic [15:0] w);
    fq_b.push_back(w);
    n_b++;
    if (!(^w)) e_b++;
    exp_b.push_back({~(^w), w});
    refresh();
  endtask

  function automatic logic [15:0] rnd_word(input bit odd);
    logic [15:0] w;
    w = 16'($urandom);
    if ((^w) != odd) w[0] = ~w[0];
    return w;
  endfunction

  task automatic compare_a(input string tag);
    check({tag, "_cnt"}, 32'(got_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      check({tag, "_word"}, 32'(got_a[i]), 32'(exp_a[i]));
    check({tag, "_rd_count"}, 32'(rd_count_a), 32'(n_a % 16));
    check({tag, "_err_count"}, 32'(err_count_a), 32'((e_a > 15) ? 15 : e_a));
    check({tag, "_par_err"}, 32'(par_err_a), 32'(e_a > 0));
    check({tag, "_pop_empty"}, 32'(viol_a), 32'(0));
    got_a.delete(); exp_a.delete(); hs_a.delete();
  endtask

  task automatic compare_b(input string tag);
    check({tag, "_cnt"}, 32'(got_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      check({tag, "_word"}, 32'(got_b[i]), 32'(exp_b[i]));
    check({tag, "_rd_count"}, 32'(rd_count_b), 32'(n_b % 65536));
    check({tag, "_err_count"}, 32'(err_count_b), 32'((e_b > 65535) ? 65535 : e_b));
    check({tag, "_par_err"}, 32'(par_err_b), 32'(e_b > 0));
    check({tag, "_pop_empty"}, 32'(viol_b), 32'(0));
    got_b.delete(); exp_b.delete();
  endtask

  task automatic clear_both();
    clr_a = 1'b1; clr_b = 1'b1;
    tick(1);
    clr_a = 1'b0; clr_b = 1'b0;
    n_a = 0; e_a = 0; n_b = 0; e_b = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    out_ready_a = 1'b0; out_ready_b = 1'b0;
    n_a = 0; e_a = 0; n_b = 0; e_b = 0;
    pops_a = 0; pops_b = 0; viol_a = 0; viol_b = 0; cyc = 0;
    pv_a = 1'b0; pv_b = 1'b0; pw_a = '0; pw_b = '0;
    refresh();
    tick(3);

    check("rst_valid_a", 32'(out_valid_a), 32'(0));
    check("rst_rinc_a", 32'(rinc_a), 32'(0));
    check("rst_regs_a", 32'({out_data_a, out_err_a, par_err_a, rd_count_a, err_count_a}), 32'(0));
    check("rst_valid_b", 32'(out_valid_b), 32'(0));
    check("rst_rinc_b", 32'(rinc_b), 32'(0));
    check("rst_data_b", 32'(out_data_b), 32'(0));
    check("rst_flags_b", 32'({out_err_b, par_err_b}), 32'(0));
    check("rst_counts_b", 32'({rd_count_b, err_count_b}), 32'(0));
    rst_n = 1'b1;
    tick(2);

    // Three odd words streamed with ready held high
    out_ready_a = 1'b1;
    pops_a = 0;
    push_a(16'h0001); push_a(16'h0007); push_a(16'h8000);
    check("t1_idle_rinc", 32'(rinc_a), 32'(0));
    tick(1);
    check("t1_load_rinc", 32'(rinc_a), 32'(1));
    check("t1_load_valid", 32'(out_valid_a), 32'(0));
    tick(1);
    check("t1_send_valid", 32'(out_valid_a), 32'(1));
    check("t1_send_data", 32'(out_data_a), 32'(16'h0001));
    tick(6);
    check("t1_hs_count", 32'(hs_a.size()), 32'(3));
    if (hs_a.size() == 3) begin
      check("t1_spacing0", 32'(hs_a[1] - hs_a[0]), 32'(2));
      check("t1_spacing1", 32'(hs_a[2] - hs_a[1]), 32'(2));
    end
    check("t1_pops", 32'(pops_a), 32'(3));
    tick(2);
    check("t1_idle", 32'({out_valid_a, rinc_a}), 32'(0));
    compare_a("t1");

    // Drop mode: even word discarded, next word popped straight away
    clear_both();
    push_a(16'h0003); push_a(16'h0001);
    tick(1);
    check("t2_rinc0", 32'(rinc_a), 32'(1));
    tick(1);
    check("t2_rinc1", 32'(rinc_a), 32'(1));
    check("t2_no_valid", 32'(out_valid_a), 32'(0));
    tick(1);
    check("t2_valid", 32'(out_valid_a), 32'(1));
    check("t2_data", 32'(out_data_a), 32'(16'h0001));
    tick(4);
    compare_a("t2");

    // Flag mode: even word forwarded with out_err
    out_ready_b = 1'b1;
    push_b(16'h0003);
    tick(2);
    check("t3_valid", 32'(out_valid_b), 32'(1));
    check("t3_data", 32'(out_data_b), 32'(16'h0003));
    check("t3_out_err", 32'(out_err_b), 32'(1));
    check("t3_par_err", 32'(par_err_b), 32'(1));
    tick(3);
    compare_b("t3");

    // Back-pressure: ready low for 10 cycles while the FIFO still has data
    out_ready_b = 1'b0;
    pops_b = 0;
    push_b(16'h0010); push_b(16'h0020);
    tick(2);
    for (int i = 0; i < 10; i++) begin
      check("t4_valid", 32'(out_valid_b), 32'(1));
      check("t4_data", 32'(out_data_b), 32'(16'h0010));
      check("t4_rinc", 32'(rinc_b), 32'(0));
      tick(1);
    end
    check("t4_pops", 32'(pops_b), 32'(1));
    out_ready_b = 1'b1;
    tick(1);
    check("t4_accepted", 32'(got_b.size()), 32'(1));
    check("t4_next_load", 32'(rinc_b), 32'(1));
    tick(5);
    compare_b("t4");

    // Narrow counters: rd_count wraps, err_count saturates, clr beats an error
    clear_both();
    for (int i = 0; i < 15; i++) push_a(rnd_word(1'b0));
    push_a(rnd_word(1'b1));
    tick(40);
    check("t5_wrap", 32'(rd_count_a), 32'(0));
    check("t5_sat", 32'(err_count_a), 32'(15));
    compare_a("t5a");
    push_a(rnd_word(1'b0)); push_a(rnd_word(1'b0)); push_a(rnd_word(1'b1));
    tick(20);
    compare_a("t5b");
    push_a(rnd_word(1'b0)); push_a(rnd_word(1'b1));
    tick(1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("t5_clr_counts", 32'({rd_count_a, err_count_a}), 32'(0));
    check("t5_clr_par", 32'(par_err_a), 32'(0));
    n_a = 1; e_a = 0;
    tick(10);
    compare_a("t5c");

    // Asynchronous reset while a word is being presented
    out_ready_b = 1'b0;
    push_b(16'h0100); push_b(16'h0200);
    tick(3);
    check("t6_pre_valid", 32'(out_valid_b), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid_b), 32'(0));
    check("t6_async_counts", 32'({rd_count_b, par_err_b}), 32'(0));
    exp_b.delete();
    exp_b.push_back({1'b0, 16'h0200});
    n_b = 1; e_b = 0; n_a = 0; e_a = 0;
    tick(2);
    rst_n = 1'b1;
    out_ready_b = 1'b1;
    tick(2);
    check("t6_restart_valid", 32'(out_valid_b), 32'(1));
    check("t6_restart_data", 32'(out_data_b), 32'(16'h0200));
    tick(3);
    compare_b("t6");

    // Random bursts and random back-pressure on both instances
    clear_both();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(7) == 0) begin
        int len;
        len = $urandom_range(4, 1);
        for (int k = 0; k < len; k++)
          push_a((k == len - 1) ? rnd_word(1'b1) : rnd_word($urandom_range(1) == 1));
      end
      if ($urandom_range(7) == 0) begin
        int len;
        len = $urandom_range(4, 1);
        for (int k = 0; k < len; k++) push_b(rnd_word($urandom_range(1) == 1));
      end
      out_ready_a = ($urandom_range(3) != 0);
      out_ready_b = ($urandom_range(3) != 0);
      tick(1);
    end
    out_ready_a = 1'b1;
    out_ready_b = 1'b1;
    tick(400);
    compare_a("rnd_a");
    compare_b("rnd_b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
